// File: rtl/full_adder_cell.sv
// WIDTH-bit ripple-carry adder built from per-bit full-adder gates, with a
// combinational result and a registered copy plus valid flag.
module full_adder_cell #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic [WIDTH-1:0] sum_q,
  output logic             co_q,
  output logic             q_valid
);

  // Per-bit nets keep fixed names so they can be probed hierarchically.
  logic [WIDTH-1:0] wire_1;
  logic [WIDTH-1:0] wire_2;
  logic [WIDTH-1:0] wire_3;
  logic [WIDTH:0]   c;

  assign c[0] = ci;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign wire_1[i] = a[i] ^ b[i];
      assign wire_2[i] = wire_1[i] & c[i];
      assign wire_3[i] = a[i] & b[i];
      assign c[i+1]    = wire_2[i] | wire_3[i];
      assign sum[i]    = wire_1[i] ^ c[i];
    end
  endgenerate

  assign co = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      co_q    <= 1'b0;
      q_valid <= 1'b0;
    end else if (en) begin
      sum_q   <= sum;
      co_q    <= co;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_full_adder_cell.sv
// Directed bench for full_adder_cell: a 1-bit instance for gate/register
// behaviour and an 8-bit instance for wrap-around and random sums.
module tb_full_adder_cell;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [0:0] a   = 1'b1;
  logic [0:0] b   = 1'b1;
  logic       ci  = 1'b0;
  logic [0:0] sum;
  logic       co;
  logic [0:0] sum_q;
  logic       co_q;
  logic       q_valid;

  logic [7:0] a8  = 8'h00;
  logic [7:0] b8  = 8'h00;
  logic       ci8 = 1'b0;
  logic [7:0] sum8;
  logic       co8;
  logic [7:0] sum_q8;
  logic       co_q8;
  logic       q_valid8;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  full_adder_cell #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .ci(ci),
    .sum(sum), .co(co), .sum_q(sum_q), .co_q(co_q), .q_valid(q_valid)
  );

  full_adder_cell #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .ci(ci8),
    .sum(sum8), .co(co8), .sum_q(sum_q8), .co_q(co_q8), .q_valid(q_valid8)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    // Reset held two cycles with en=1, a=1, b=1
    repeat (2) begin
      edge_sample();
      check("rst_sum_q", sum_q, 0);
      check("rst_co_q", co_q, 0);
      check("rst_q_valid", q_valid, 0);
      check("rst_sum_comb", sum, 0);
      check("rst_co_comb", co, 1);
      check("rst_q_valid8", q_valid8, 0);
    end

    // Capture 1+0+0
    @(negedge clk);
    rst = 1'b0; en = 1'b1; a = 1'b1; b = 1'b0; ci = 1'b0;
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
    edge_sample();
    check("cap_sum_q", sum_q, 1);
    check("cap_co_q", co_q, 0);
    check("cap_q_valid", q_valid, 1);
    check("cap_sum_q8", sum_q8, 8'h47);
    check("cap_q_valid8", q_valid8, 1);

    // Hold with en=0 while inputs change to 1,1,1
    @(negedge clk);
    en = 1'b0; a = 1'b1; b = 1'b1; ci = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    edge_sample();
    edge_sample();
    check("hold_sum_q", sum_q, 1);
    check("hold_co_q", co_q, 0);
    check("hold_q_valid", q_valid, 1);
    check("hold_sum_q8", sum_q8, 8'h47);
    check("hold_co_q8", co_q8, 0);
    check("hold_sum_comb", sum, 1);
    check("hold_co_comb", co, 1);

    // Capture 1+1+1 to get co_q=1, then reset wins over en
    @(negedge clk);
    en = 1'b1;
    edge_sample();
    check("cap2_sum_q", sum_q, 1);
    check("cap2_co_q", co_q, 1);
    check("cap2_co_q8", co_q8, 1);
    check("cap2_sum_q8", sum_q8, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    edge_sample();
    check("rstwin_sum_q", sum_q, 0);
    check("rstwin_co_q", co_q, 0);
    check("rstwin_q_valid", q_valid, 0);
    check("rstwin_sum_q8", sum_q8, 0);
    check("rstwin_sum_comb", sum, 1);
    check("rstwin_co_comb", co, 1);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // Exhaustive 1-bit sweep
    for (int v = 0; v < 8; v++) begin
      a = v[2]; b = v[1]; ci = v[0];
      #1;
      exp2 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      check($sformatf("sweep_%0d", v), {co, sum}, exp2);
    end

    // Internal net probes
    a = 1'b1; b = 1'b1; ci = 1'b1;
    #1;
    check("p111_sum", sum, 1);
    check("p111_co", co, 1);
    check("p111_wire_1", dut.wire_1, 0);
    check("p111_wire_3", dut.wire_3, 1);
    a = 1'b1; b = 1'b0; ci = 1'b1;
    #1;
    check("p101_wire_1", dut.wire_1, 1);
    check("p101_wire_2", dut.wire_2, 1);
    check("p101_sum", sum, 0);
    check("p101_co", co, 1);

    // 8-bit wrap-around
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    #1;
    check("w8_ff_01_sum", sum8, 8'h00);
    check("w8_ff_01_co", co8, 1);
    a8 = 8'h7F; b8 = 8'h80; ci8 = 1'b1;
    #1;
    check("w8_7f_80_sum", sum8, 8'h00);
    check("w8_7f_80_co", co8, 1);
    a8 = 8'h7F; b8 = 8'h80; ci8 = 1'b0;
    #1;
    check("w8_7f_80_c0", {co8, sum8}, 9'h0FF);
    a8 = 8'h55; b8 = 8'hAA; ci8 = 1'b1;
    #1;
    check("w8_55_aa_c1", {co8, sum8}, 9'h100);

    // Random 8-bit vectors
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      a8 = ra; b8 = rb; ci8 = rc;
      #1;
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      check($sformatf("rand_%0d", n), {co8, sum8}, exp9);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
